// File: rtl/ifu_pc.sv
// Fetch-stage PC register and fetch controller. Fetches one word per REQ/HOLD round
// trip; optional fetch timeout flag is compiled in with IFU_TIMEOUT_EN.
module ifu_pc #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] npc,
    output logic [31:2] pc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready
`ifdef IFU_TIMEOUT_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:2] r_pc;
    logic [31:0] r_inst;
    logic        w_fetch_done;
    logic        w_consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // pc and inst only move on their own handshake, so both hold across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_inst <= 32'h0;
        end else begin
            if (w_consume)    r_pc   <= npc;
            if (w_fetch_done) r_inst <= imem_rdata;
        end
    end

    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign imem_req   = (r_state == S_REQ)  && !rst;
    assign inst_valid = (r_state == S_HOLD) && !rst;

`ifdef IFU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_wait;
    logic          r_fault;

    // Counter saturates at TIMEOUT; the flag is set on the edge the count reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else if (r_state == S_REQ && !imem_ack) begin
            if (r_wait != CW'(TIMEOUT)) r_wait <= r_wait + 1'b1;
            if (r_wait == CW'(TIMEOUT - 1)) r_fault <= 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    assign fetch_fault = r_fault && !rst;
`endif

endmodule
